// File: rtl/cv32e40p_voter_tmr_mon_if.sv
// Purpose: bundles the triplicated inputs, voted result and fault-monitor signals of the TMR voter.
// Latency: none (wiring only).
// Backpressure: none on the vote path; the resync handshake is req/ack.
interface cv32e40p_voter_tmr_mon_if #(
    parameter int WIDTH = 32,
    parameter int N_CH  = 1,
    parameter int CNT_W = 4
);
    logic [N_CH*WIDTH-1:0] res_a_i;
    logic [N_CH*WIDTH-1:0] res_b_i;
    logic [N_CH*WIDTH-1:0] res_c_i;
    logic                  check_en_i;
    logic                  clr_i;
    logic [N_CH*WIDTH-1:0] result_o;
    logic [2:0]            mismatch_o;
    logic [3*CNT_W-1:0]    err_cnt_o;
    logic                  resync_req_o;
    logic [1:0]            resync_lane_o;
    logic                  resync_ack_i;
    logic                  resync_busy_o;
    logic                  fail_o;
    logic [1:0]            state_o;

    // Master: the triplicated sources plus whoever services resync requests.
    modport master (
        output res_a_i, res_b_i, res_c_i, check_en_i, clr_i, resync_ack_i,
        input  result_o, mismatch_o, err_cnt_o, resync_req_o, resync_lane_o,
               resync_busy_o, fail_o, state_o
    );

    // Slave: the voter/monitor itself.
    modport slave (
        input  res_a_i, res_b_i, res_c_i, check_en_i, clr_i, resync_ack_i,
        output result_o, mismatch_o, err_cnt_o, resync_req_o, resync_lane_o,
               resync_busy_o, fail_o, state_o
    );
endinterface

// File: rtl/cv32e40p_voter_tmr_mon.sv
// Purpose: N-channel bitwise TMR majority voter with per-lane mismatch counting and a resync/fail FSM.
// Latency: result_o is 0 cycles (REG_OUT=0) or 1 cycle (REG_OUT=1); mismatch/counters/FSM update on the next edge.
// Backpressure: none on the vote path; a resync request is held until resync_ack_i is sampled high.
module cv32e40p_voter_tmr_mon #(
    parameter int WIDTH      = 32,
    parameter int N_CH       = 1,
    parameter int REG_OUT    = 0,
    parameter int CNT_W      = 4,
    parameter int ERR_THRESH = 3,
    parameter int RESYNC_CYC = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    cv32e40p_voter_tmr_mon_if.slave       bus
);

    localparam int DW    = N_CH * WIDTH;
    localparam int TMR_W = (RESYNC_CYC > 1) ? $clog2(RESYNC_CYC) : 1;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] THRESH   = CNT_W'(ERR_THRESH);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(RESYNC_CYC - 1);

    typedef enum logic [1:0] {
        ST_OK     = 2'd0,
        ST_REQ    = 2'd1,
        ST_RESYNC = 2'd2,
        ST_FAIL   = 2'd3
    } state_e;

    logic [DW-1:0]    vote;
    logic [2:0]       mis_raw;
    logic             single_fault;
    logic             multi_fault;

    logic [2:0]       mismatch_d, mismatch_q;
    logic [CNT_W-1:0] cnt_d [3];
    logic [CNT_W-1:0] cnt_q [3];
    state_e           state_d, state_q;
    logic [1:0]       lane_d, lane_q;
    logic [TMR_W-1:0] tmr_d, tmr_q;

    // Bitwise majority across the three copies and the raw per-lane disagreement vector.
    always_comb begin
        vote         = (bus.res_a_i & bus.res_b_i) | (bus.res_a_i & bus.res_c_i) |
                       (bus.res_b_i & bus.res_c_i);
        mis_raw[0]   = |(bus.res_a_i ^ vote);
        mis_raw[1]   = |(bus.res_b_i ^ vote);
        mis_raw[2]   = |(bus.res_c_i ^ vote);
        single_fault = (mis_raw == 3'b001) || (mis_raw == 3'b010) || (mis_raw == 3'b100);
        multi_fault  = (mis_raw[0] & mis_raw[1]) | (mis_raw[0] & mis_raw[2]) |
                       (mis_raw[1] & mis_raw[2]);
        mismatch_d   = mis_raw;
    end

    generate
        if (REG_OUT != 0) begin : g_reg_out
            logic [DW-1:0] result_d, result_q;

            // Output stage mirrors the combinational vote.
            always_comb begin
                result_d = vote;
            end

            // One flop stage on the voted result.
            always_ff @(posedge clk) begin
                if (rst) result_q <= '0;
                else     result_q <= result_d;
            end

            assign bus.result_o = result_q;
        end else begin : g_comb_out
            assign bus.result_o = vote;
        end
    endgenerate

    // Counter update and fault FSM; clr dominates, then multi-lane escalation, then normal flow.
    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        tmr_d   = tmr_q;
        for (int k = 0; k < 3; k++) cnt_d[k] = cnt_q[k];

        if (bus.clr_i) begin
            for (int k = 0; k < 3; k++) cnt_d[k] = '0;
            state_d = ST_OK;
            lane_d  = 2'd0;
            tmr_d   = '0;
        end else if (bus.check_en_i && multi_fault) begin
            state_d = ST_FAIL;
        end else begin
            // Resync is in progress for some lane: its counter is about to be cleared, so
            // counting is frozen for all lanes until the FSM is back in OK.
            if (bus.check_en_i && single_fault && (state_q != ST_RESYNC)) begin
                for (int k = 0; k < 3; k++) begin
                    if (mis_raw[k] && (cnt_q[k] != CNT_MAX)) cnt_d[k] = cnt_q[k] + 1'b1;
                end
            end

            case (state_q)
                ST_OK: begin
                    // Descending scan so the lowest qualifying lane is the one that sticks.
                    for (int k = 2; k >= 0; k--) begin
                        if (cnt_d[k] >= THRESH) begin
                            state_d = ST_REQ;
                            lane_d  = 2'(k);
                        end
                    end
                end
                ST_REQ: begin
                    if (bus.resync_ack_i) begin
                        state_d = ST_RESYNC;
                        tmr_d   = TMR_LOAD;
                    end
                end
                ST_RESYNC: begin
                    if (tmr_q == '0) begin
                        state_d = ST_OK;
                        for (int k = 0; k < 3; k++) begin
                            if (lane_q == 2'(k)) cnt_d[k] = '0;
                        end
                    end else begin
                        tmr_d = tmr_q - 1'b1;
                    end
                end
                ST_FAIL: begin
                    state_d = ST_FAIL;
                end
                default: begin
                    state_d = ST_OK;
                end
            endcase
        end
    end

    // State, counters, lane select, dwell timer and registered mismatch vector.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_OK;
            lane_q     <= 2'd0;
            tmr_q      <= '0;
            mismatch_q <= 3'b000;
            for (int k = 0; k < 3; k++) cnt_q[k] <= '0;
        end else begin
            state_q    <= state_d;
            lane_q     <= lane_d;
            tmr_q      <= tmr_d;
            mismatch_q <= mismatch_d;
            for (int k = 0; k < 3; k++) cnt_q[k] <= cnt_d[k];
        end
    end

    assign bus.mismatch_o    = mismatch_q;
    assign bus.err_cnt_o     = {cnt_q[2], cnt_q[1], cnt_q[0]};
    assign bus.resync_req_o  = (state_q == ST_REQ);
    assign bus.resync_lane_o = lane_q;
    assign bus.resync_busy_o = (state_q == ST_RESYNC);
    assign bus.fail_o        = (state_q == ST_FAIL);
    assign bus.state_o       = state_q;

endmodule

// File: tb/tb_cv32e40p_voter_tmr_mon.sv
// Purpose: randomized + directed bench for the TMR voter/monitor with a queue-based scoreboard.
// Latency: expectations are checked one cycle after the stimulus that produced them.
// Backpressure: none; resync_ack_i is driven directly by the stimulus.
module tb_cv32e40p_voter_tmr_mon;

    localparam int WIDTH      = 32;
    localparam int N_CH       = 2;
    localparam int REG_OUT    = 1;
    localparam int CNT_W      = 2;
    localparam int ERR_THRESH = 3;
    localparam int RESYNC_CYC = 4;
    localparam int DW         = N_CH * WIDTH;
    localparam int CMAX       = (1 << CNT_W) - 1;

    typedef struct {
        logic [DW-1:0] res;
        logic [2:0]    mis;
        int            c0, c1, c2;
        int            st;
        int            lane;
        bit            chk_lane;
    } exp_t;

    logic clk;
    logic rst;
    cv32e40p_voter_tmr_mon_if #(.WIDTH(WIDTH), .N_CH(N_CH), .CNT_W(CNT_W)) bus_if ();

    cv32e40p_voter_tmr_mon #(
        .WIDTH(WIDTH), .N_CH(N_CH), .REG_OUT(REG_OUT), .CNT_W(CNT_W),
        .ERR_THRESH(ERR_THRESH), .RESYNC_CYC(RESYNC_CYC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model state
    int m_cnt[3];
    int m_st;      // 0 OK, 1 REQ, 2 RESYNC, 3 FAIL
    int m_lane;
    int m_rem;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Drive one cycle of stimulus and push the state expected right after the next edge.
    task automatic cyc(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] c,
                       input bit ce, input bit cl, input bit ack, input bit r);
        logic [DW-1:0] v;
        logic [2:0]    mis;
        int            nm;
        exp_t          e;
        @(posedge clk);
        #2;
        bus_if.res_a_i      = a;
        bus_if.res_b_i      = b;
        bus_if.res_c_i      = c;
        bus_if.check_en_i   = ce;
        bus_if.clr_i        = cl;
        bus_if.resync_ack_i = ack;
        rst                 = r;

        v   = (a & b) | (a & c) | (b & c);
        mis = {c != v, b != v, a != v};
        nm  = int'(mis[0]) + int'(mis[1]) + int'(mis[2]);

        if (r) begin
            for (int k = 0; k < 3; k++) m_cnt[k] = 0;
            m_st = 0; m_lane = 0; m_rem = 0;
            e.res = '0;
            e.mis = 3'b000;
        end else begin
            e.res = v;
            e.mis = mis;
            if (cl) begin
                for (int k = 0; k < 3; k++) m_cnt[k] = 0;
                m_st = 0;
            end else if (ce && nm >= 2) begin
                m_st = 3;
            end else begin
                if (ce && nm == 1 && m_st != 2) begin
                    for (int k = 0; k < 3; k++)
                        if (mis[k] && m_cnt[k] < CMAX) m_cnt[k] = m_cnt[k] + 1;
                end
                if (m_st == 0) begin
                    for (int k = 0; k < 3; k++) begin
                        if (m_st == 0 && m_cnt[k] >= ERR_THRESH) begin
                            m_st   = 1;
                            m_lane = k;
                        end
                    end
                end else if (m_st == 1) begin
                    if (ack) begin
                        m_st  = 2;
                        m_rem = RESYNC_CYC;
                    end
                end else if (m_st == 2) begin
                    m_rem = m_rem - 1;
                    if (m_rem == 0) begin
                        m_cnt[m_lane] = 0;
                        m_st = 0;
                    end
                end
            end
        end
        e.c0 = m_cnt[0]; e.c1 = m_cnt[1]; e.c2 = m_cnt[2];
        e.st = m_st;
        e.lane = m_lane;
        e.chk_lane = r || (m_st == 1);
        exp_q.push_back(e);
    endtask

    // Monitor: every cycle the DUT presents a full output set; compare against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("result_o",   bus_if.result_o, e.res);
                chk("mismatch_o", DW'(bus_if.mismatch_o), DW'(e.mis));
                chk("err_cnt0",   DW'(bus_if.err_cnt_o[0*CNT_W +: CNT_W]), DW'(e.c0));
                chk("err_cnt1",   DW'(bus_if.err_cnt_o[1*CNT_W +: CNT_W]), DW'(e.c1));
                chk("err_cnt2",   DW'(bus_if.err_cnt_o[2*CNT_W +: CNT_W]), DW'(e.c2));
                chk("state_o",    DW'(bus_if.state_o), DW'(e.st));
                chk("resync_req", DW'(bus_if.resync_req_o), DW'(e.st == 1));
                chk("resync_busy",DW'(bus_if.resync_busy_o), DW'(e.st == 2));
                chk("fail_o",     DW'(bus_if.fail_o), DW'(e.st == 3));
                if (e.chk_lane)
                    chk("resync_lane", DW'(bus_if.resync_lane_o), DW'(e.lane));
            end
        end
    end

    function automatic logic [DW-1:0] flip(input logic [DW-1:0] v, input int b);
        logic [DW-1:0] one;
        one = 1;
        return v ^ (one << b);
    endfunction

    initial begin
        logic [DW-1:0] d;
        logic [DW-1:0] base, la, lb, lc;
        rst                 = 1'b1;
        bus_if.res_a_i      = '0;
        bus_if.res_b_i      = '0;
        bus_if.res_c_i      = '0;
        bus_if.check_en_i   = 1'b0;
        bus_if.clr_i        = 1'b0;
        bus_if.resync_ack_i = 1'b0;
        for (int k = 0; k < 3; k++) m_cnt[k] = 0;
        m_st = 0; m_lane = 0; m_rem = 0;
        d = {32'hDEADBEEF, 32'hDEADBEEF};

        // Reset
        repeat (2) cyc(d, d, d, 1, 0, 0, 1);
        // Equal inputs
        repeat (3) cyc(d, d, d, 1, 0, 0, 0);
        // Lane 1 bit 5 for three cycles -> REQ on lane 1
        repeat (3) cyc(d, flip(d, 5), d, 1, 0, 0, 0);
        // Request held without ack, then one-cycle ack, then RESYNC dwell
        repeat (10) cyc(d, d, d, 1, 0, 0, 0);
        cyc(d, d, d, 1, 0, 1, 0);
        repeat (6) cyc(d, d, d, 1, 0, 0, 0);
        // Two-lane fault -> sticky FAIL, then clr
        cyc(flip(d, 0), d, flip(d, 7), 1, 0, 0, 0);
        repeat (3) cyc(d, d, d, 1, 0, 0, 0);
        cyc(d, d, d, 1, 1, 0, 0);
        repeat (2) cyc(d, d, d, 1, 0, 0, 0);
        // Saturation on lane 2, then masked lane-0 fault
        repeat (5) cyc(d, d, flip(d, 40), 1, 0, 0, 0);
        repeat (2) cyc(flip(d, 3), d, d, 0, 0, 0, 0);
        cyc(d, d, d, 1, 0, 1, 0);
        repeat (6) cyc(d, d, d, 1, 0, 0, 0);
        // Reset during REQ
        repeat (3) cyc(flip(d, 63), d, d, 1, 0, 0, 0);
        cyc(d, d, d, 1, 0, 0, 1);
        repeat (3) cyc(d, d, d, 1, 0, 0, 0);
        // Reset during RESYNC
        repeat (3) cyc(flip(d, 12), d, d, 1, 0, 0, 0);
        cyc(d, d, d, 1, 0, 1, 0);
        cyc(d, d, d, 1, 0, 0, 0);
        cyc(d, d, d, 1, 0, 0, 1);
        repeat (3) cyc(d, d, d, 1, 0, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            base = {$urandom, $urandom};
            la = base; lb = base; lc = base;
            if ($urandom_range(0, 11) == 0) la = flip(base, int'($urandom_range(0, DW - 1)));
            if ($urandom_range(0, 11) == 0) lb = flip(base, int'($urandom_range(0, DW - 1)));
            if ($urandom_range(0, 11) == 0) lc = flip(base, int'($urandom_range(0, DW - 1)));
            cyc(la, lb, lc,
                $urandom_range(0, 9) != 0,
                $urandom_range(0, 29) == 0,
                $urandom_range(0, 3) == 0,
                $urandom_range(0, 199) == 0);
        end

        repeat (3) @(posedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cv32e40p_voter_tmr_mon.md
Name: cv32e40p_voter_tmr_mon

Overview:
Parametrised N-channel TMR majority voter with fault monitoring. It votes three redundant copies of up to N_CH buses and registers per-lane mismatch events. It keeps saturating per-lane error counters and runs a fault FSM that requests a lane resync over a req/ack handshake. It escalates to a sticky FAIL state on a multi-lane fault. It sits between the triplicated instances (CSR, decoder, etc.) and the core datapath, and replaces the plain per-output voters.

Parameters:
WIDTH, 32, bit width of each channel
N_CH, 1, number of voted channels (≥1)
REG_OUT, 0, 0: result_o combinational; 1: result_o registered (1-cycle latency)
CNT_W, 4, width of each per-lane error counter
ERR_THRESH, 3, counter value that triggers a resync request (1..2^CNT_W-1)
RESYNC_CYC, 4, cycles held in RESYNC after ack (≥1)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
res_a_i  in  N_CH*WIDTH  lane 0 copies, channel c at bits [c*WIDTH +: WIDTH]
res_b_i  in  N_CH*WIDTH  lane 1 copies
res_c_i  in  N_CH*WIDTH  lane 2 copies
check_en_i  in  1  enables mismatch accounting (voting is always active)
clr_i  in  1  clears counters, sticky flags and FAIL
result_o  out  N_CH*WIDTH  bitwise majority
mismatch_o  out  3  registered per-lane mismatch of the previous cycle
err_cnt_o  out  3*CNT_W  per-lane saturating error counters, lane k at [k*CNT_W +: CNT_W]
resync_req_o  out  1  resync request
resync_lane_o  out  2  lane to resync (0..2), valid while resync_req_o=1
resync_ack_i  in  1  resync acknowledge
resync_busy_o  out  1  high in RESYNC
fail_o  out  1  sticky uncorrectable-fault flag
state_o  out  2  FSM state: OK=0, REQ=1, RESYNC=2, FAIL=3

Behaviour:
- Vote: result = (a&b)|(a&c)|(b&c) per bit, all channels. REG_OUT=1 adds one flop stage to result_o, reset value 0.
- Lane k mismatches when any bit of any channel of lane k differs from result. The raw mismatch vector is computed combinationally and registered into mismatch_o every cycle, regardless of check_en_i.
- Reset: result_o reg=0, mismatch_o=0, err_cnt_o=0, resync_req_o=0, resync_lane_o=0, resync_busy_o=0, fail_o=0, state=OK.
- Accounting (check_en_i=1), evaluated on the raw, same-cycle mismatch vector:
  - Exactly one lane mismatching: that lane's counter increments, saturating at 2^CNT_W-1.
  - ≥2 lanes mismatching: go to FAIL and set fail_o on the next edge. This applies from any state and has the highest priority after rst and clr_i.
- FSM:
  - OK: when a lane's counter (after update) ≥ ERR_THRESH, go to REQ. Set resync_lane_o to that lane; if several lanes qualify, the lowest index wins.
  - REQ: resync_req_o=1 and resync_lane_o held stable until ack. On resync_ack_i=1 sampled at an edge, go to RESYNC. resync_req_o deasserts in the same edge.
  - RESYNC: resync_busy_o=1 for exactly RESYNC_CYC cycles. Counter increments are suppressed in this state; ≥2-lane faults are still detected. On exit, clear the target lane's counter and return to OK.
  - FAIL: stays here until clr_i or rst; voting continues.
- clr_i=1: all counters 0, fail_o=0, state=OK, resync_req_o=0 on the next edge. rst has priority over clr_i.
- resync_ack_i is ignored outside REQ.
- rst mid-handshake aborts the request: no residual req or busy.

Test Plan:
- Equal inputs a=b=c=0xDEADBEEF, N_CH=2, REG_OUT=1 -> result_o=0xDEADBEEF (both channels) one cycle later; mismatch_o=0; counters stay 0.
- Lane 1 bit 5 flipped for 3 consecutive cycles, check_en_i=1, ERR_THRESH=3 -> err_cnt lane1=1,2,3; state=REQ and resync_req_o=1 with resync_lane_o=1 on the edge after the third count.
- In REQ, ack held low 10 cycles and then pulsed for 1 cycle -> req stays high and lane stays 1 throughout; then busy=1 for 4 cycles (RESYNC_CYC=4); lane1 counter=0 and state=OK afterwards.
- Lane 0 differs on bit 0 and lane 2 differs on bit 7 in the same cycle -> fail_o=1 and state=FAIL on the next edge, sticky while inputs recover; clr_i pulse -> fail_o=0, state=OK.
- Single-lane faults with CNT_W=2 and check_en_i=1 until saturation -> counter saturates at 3 with no wrap. With check_en_i=0 and a lane fault -> counters unchanged, but mismatch_o still reports the lane.
- rst asserted during REQ and during RESYNC -> all outputs return to reset values on the next edge; no req after rst is released.
